seven_seg_capture: RTL and testbench

//  Reverse of the hex display driver. Samples a multiplexed, active-low 7-segment bus
//  (segment lines plus a digit-select strobe) and debounces each digit. Decodes each

---
 rtl/seven_seg_capture.sv | 142 ++++++++++++++
 tb/tb_seven_seg_capture.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seven_seg_capture.sv
// rtl/seven_seg_capture.sv - multiplexed 7-segment bus capture, debounce, decode and frame output
// Rebuilds NUM_DIGITS debounced digit nibbles from an active-low scanned display into a valid/ready frame.
module seven_seg_capture #(
  parameter int NUM_DIGITS    = 6,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] out_digits,
  output logic [NUM_DIGITS-1:0]   out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t                  r_state, w_state_nxt;
  logic [6:0]              r_seg, r_prev_seg;
  logic [NUM_DIGITS-1:0]   r_dig, r_prev_dig;
  logic [CNT_W-1:0]        r_cnt;
  logic [NUM_DIGITS-1:0]   r_mask, r_ferr, r_out_err;
  logic [4*NUM_DIGITS-1:0] r_frame, r_out_digits;
  logic                    r_overrun;

  logic [NUM_DIGITS-1:0]   w_sel, w_mask_nxt, w_ferr_nxt;
  logic [4*NUM_DIGITS-1:0] w_frame_nxt;
  logic                    w_onehot, w_same, w_cap, w_done, w_load, w_overrun_nxt, w_bad;
  logic [3:0]              w_nib;

  assign w_sel    = ~r_dig;
  assign w_onehot = (w_sel != '0) && ((w_sel & (w_sel - 1'b1)) == '0);
  assign w_same   = w_onehot && (r_seg == r_prev_seg) && (r_dig == r_prev_dig);
  // Fires only on the transition into saturation, so one capture per stable period.
  assign w_cap    = w_same && (r_cnt == CNT_MAX - 1'b1);

  always_comb begin
    w_nib = 4'hE;
    w_bad = 1'b1;
    case (r_seg)
      7'h40: begin w_nib = 4'h0; w_bad = 1'b0; end
      7'h79: begin w_nib = 4'h1; w_bad = 1'b0; end
      7'h24: begin w_nib = 4'h2; w_bad = 1'b0; end
      7'h30: begin w_nib = 4'h3; w_bad = 1'b0; end
      7'h19: begin w_nib = 4'h4; w_bad = 1'b0; end
      7'h12: begin w_nib = 4'h5; w_bad = 1'b0; end
      7'h02: begin w_nib = 4'h6; w_bad = 1'b0; end
      7'h78: begin w_nib = 4'h7; w_bad = 1'b0; end
      7'h00: begin w_nib = 4'h8; w_bad = 1'b0; end
      7'h10: begin w_nib = 4'h9; w_bad = 1'b0; end
      7'h7F: begin w_nib = 4'hF; w_bad = 1'b0; end
      default: begin w_nib = 4'hE; w_bad = 1'b1; end
    endcase
  end

  always_comb begin
    w_frame_nxt = r_frame;
    w_ferr_nxt  = r_ferr;
    w_mask_nxt  = r_mask;
    if (w_cap) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_sel[i]) begin
          w_frame_nxt[4*i +: 4] = w_nib;
          w_ferr_nxt[i]         = w_bad;
          w_mask_nxt[i]         = 1'b1;
        end
      end
    end
  end

  assign w_done = w_cap && (&w_mask_nxt);

  always_comb begin
    w_state_nxt   = r_state;
    w_load        = 1'b0;
    w_overrun_nxt = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_done) begin
          w_load      = 1'b1;
          w_state_nxt = S_FULL;
        end
      end
      S_FULL: begin
        if (w_done) begin
          if (out_ready) w_load = 1'b1;
          else           w_overrun_nxt = 1'b1;
        end else if (out_ready) begin
          w_state_nxt = S_EMPTY;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_EMPTY;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg        <= 7'h7F;
      r_prev_seg   <= 7'h7F;
      r_dig        <= '1;
      r_prev_dig   <= '1;
      r_cnt        <= '0;
      r_mask       <= '0;
      r_frame      <= '0;
      r_ferr       <= '0;
      r_out_digits <= '0;
      r_out_err    <= '0;
      r_overrun    <= 1'b0;
    end else begin
      r_seg      <= seg_in;
      r_dig      <= dig_sel;
      r_prev_seg <= r_seg;
      r_prev_dig <= r_dig;
      if (!w_same)              r_cnt <= '0;
      else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
      r_mask    <= w_done ? '0 : w_mask_nxt;
      r_frame   <= w_frame_nxt;
      r_ferr    <= w_ferr_nxt;
      r_overrun <= w_overrun_nxt;
      if (w_load) begin
        r_out_digits <= w_frame_nxt;
        r_out_err    <= w_ferr_nxt;
      end
    end
  end

  assign out_digits = r_out_digits;
  assign out_err    = r_out_err;
  assign out_valid  = (r_state == S_FULL);
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_seven_seg_capture.sv
// tb/tb_seven_seg_capture.sv - directed self-checking bench for seven_seg_capture
module tb_seven_seg_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  seg_in = 7'h7F;
  logic [5:0]  dig_sel = 6'h3F;
  logic [23:0] out_digits;
  logic [5:0]  out_err;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        overrun;

  int errors = 0;
  int checks = 0;
  int valid_cycles = 0;
  int ov_cycles = 0;
  int base_v, base_o;
  logic [23:0] last_digits = '0;
  logic [5:0]  last_err = '0;

  seven_seg_capture #(.NUM_DIGITS(6), .STABLE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .seg_in(seg_in), .dig_sel(dig_sel),
    .out_digits(out_digits), .out_err(out_err), .out_valid(out_valid),
    .out_ready(out_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid) begin
      valid_cycles++;
      last_digits = out_digits;
      last_err    = out_err;
    end
    if (overrun) ov_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] enc(input logic [3:0] v);
    case (v)
      4'h0: enc = 7'h40; 4'h1: enc = 7'h79; 4'h2: enc = 7'h24; 4'h3: enc = 7'h30;
      4'h4: enc = 7'h19; 4'h5: enc = 7'h12; 4'h6: enc = 7'h02; 4'h7: enc = 7'h78;
      4'h8: enc = 7'h00; 4'h9: enc = 7'h10; default: enc = 7'h7F;
    endcase
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic show(input int d, input logic [6:0] s, input int n);
    logic [5:0] one;
    one = 6'b1;
    dig_sel = ~(one << d);
    seg_in  = s;
    cyc(n);
  endtask

  task automatic idle(input int n);
    dig_sel = 6'h3F;
    seg_in  = 7'h7F;
    cyc(n);
  endtask

  task automatic frame(input logic [23:0] v);
    for (int d = 5; d >= 0; d--) show(d, enc(v[4*d +: 4]), 6);
    idle(3);
  endtask

  task automatic mark;
    base_v = valid_cycles;
    base_o = ov_cycles;
  endtask

  initial begin
    cyc(3);
    check("rst_digits", 32'(out_digits), 32'h0);
    check("rst_err", 32'(out_err), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    reset = 1'b0;
    cyc(2);

    // Basic frame, consumer always ready
    mark();
    frame(24'h123456);
    check("basic_valid_cycles", 32'(valid_cycles - base_v), 32'd1);
    check("basic_digits", 32'(last_digits), 32'h123456);
    check("basic_err", 32'(last_err), 32'h0);
    check("basic_valid_low", 32'(out_valid), 32'h0);

    // Digit 3 held too briefly, then rescanned
    mark();
    show(5, enc(4'h7), 6); show(4, enc(4'h8), 6); show(3, enc(4'h9), 4);
    show(2, enc(4'h0), 6); show(1, enc(4'h1), 6); show(0, enc(4'h2), 6);
    idle(3);
    check("short_no_valid", 32'(valid_cycles - base_v), 32'd0);
    show(3, enc(4'h9), 6);
    idle(3);
    check("rescan_valid_cycles", 32'(valid_cycles - base_v), 32'd1);
    check("rescan_digits", 32'(last_digits), 32'h789012);

    // Unrecognised and blank patterns
    mark();
    show(5, enc(4'h1), 6); show(4, enc(4'h2), 6); show(3, enc(4'h3), 6);
    show(2, 7'h55, 6); show(1, enc(4'h5), 6); show(0, 7'h7F, 6);
    idle(3);
    check("err_valid_cycles", 32'(valid_cycles - base_v), 32'd1);
    check("err_mask", 32'(last_err), 32'h04);
    check("err_digits", 32'(last_digits), 32'h123E5F);

    // Backpressure and overrun
    out_ready = 1'b0;
    mark();
    frame(24'h123456);
    frame(24'h654321);
    check("ovr_pulse_cycles", 32'(ov_cycles - base_o), 32'd1);
    check("ovr_held_digits", 32'(out_digits), 32'h123456);
    check("ovr_held_err", 32'(out_err), 32'h0);
    check("ovr_held_valid", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    cyc(1);
    check("ovr_accept_drop", 32'(out_valid), 32'h0);

    // Asynchronous reset while a frame is held
    out_ready = 1'b0;
    frame(24'h111111);
    check("async_pre_valid", 32'(out_valid), 32'h1);
    #3 reset = 1'b1;
    #1;
    check("async_valid", 32'(out_valid), 32'h0);
    check("async_digits", 32'(out_digits), 32'h0);
    check("async_err", 32'(out_err), 32'h0);
    cyc(1);
    reset = 1'b0;
    out_ready = 1'b1;
    cyc(1);

    // Partial frame discarded by reset
    mark();
    show(5, enc(4'h1), 6); show(4, enc(4'h2), 6); show(3, enc(4'h3), 6);
    idle(2);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    show(2, enc(4'h6), 6); show(1, enc(4'h5), 6); show(0, enc(4'h4), 6);
    idle(3);
    check("stale_no_valid", 32'(valid_cycles - base_v), 32'd0);
    show(5, enc(4'h9), 6); show(4, enc(4'h8), 6); show(3, enc(4'h7), 6);
    idle(3);
    check("fresh_valid_cycles", 32'(valid_cycles - base_v), 32'd1);
    check("fresh_digits", 32'(last_digits), 32'h987654);
    check("fresh_err", 32'(last_err), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
